demux_outpico: RTL and testbench



---
 rtl/demux_outpico_pkg.sv | 34 +++
 rtl/demux_outpico_rtc_wr_handshake.sv | 54 +++++
 rtl/demux_outpico.sv | 100 ++++++++++
 tb/tb_demux_outpico.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_outpico_pkg.sv
// Port map, handshake state encoding and status bit positions shared by the
// PicoBlaze output decoder and the input mux.
package demux_outpico_pkg;

  localparam logic [7:0] PORT_SEG      = 8'h00;
  localparam logic [7:0] PORT_MIN      = 8'h01;
  localparam logic [7:0] PORT_HORA     = 8'h02;
  localparam logic [7:0] PORT_DIA      = 8'h03;
  localparam logic [7:0] PORT_MES      = 8'h04;
  localparam logic [7:0] PORT_YEAR     = 8'h05;
  localparam logic [7:0] PORT_SEG_TIM  = 8'h06;
  localparam logic [7:0] PORT_MIN_TIM  = 8'h07;
  localparam logic [7:0] PORT_HORA_TIM = 8'h08;
  localparam logic [7:0] PORT_CMD      = 8'h0A;
  localparam logic [7:0] PORT_STATUS   = 8'h0B;
  localparam logic [7:0] PORT_CLR      = 8'h0C;

  localparam int NUM_DATA = 9;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_OVERRUN = 1;
  localparam int STAT_ERR_BCD = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } hs_state_t;

  function automatic logic is_bcd(input logic [7:0] value);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/demux_outpico_rtc_wr_handshake.sv
// Four-phase wr_req/wr_ack handshake toward the RTC write engine.
//   state       | meaning
//   ST_IDLE     | no transfer, wr_req=0, busy=0
//   ST_REQ      | wr_req=1, waiting for wr_ack high
//   ST_WAIT_LOW | wr_req=0, busy=1, waiting for wr_ack to drop
module rtc_wr_handshake
  import demux_outpico_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic wr_ack,
  output logic wr_req,
  output logic busy
);

  hs_state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      wr_req <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_REQ;
            wr_req <= 1'b1;
            busy   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (wr_ack) begin
            state  <= ST_WAIT_LOW;
            wr_req <= 1'b0;
          end
        end
        ST_WAIT_LOW: begin
          if (!wr_ack) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          wr_req <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/demux_outpico.sv
// PicoBlaze output-port decoder: holding registers, command launch and status flags.
// Optional BCD validation of data writes: define DEMUX_OUTPICO_BCD_CHECK_EN.
module demux_outpico
  import demux_outpico_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       write_strobe,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       wr_ack,
  output logic [7:0] seg_out,
  output logic [7:0] min_out,
  output logic [7:0] hora_out,
  output logic [7:0] dia_out,
  output logic [7:0] mes_out,
  output logic [7:0] year_out,
  output logic [7:0] seg_tim_out,
  output logic [7:0] min_tim_out,
  output logic [7:0] hora_tim_out,
  output logic [7:0] cmd_out,
  output logic       wr_req,
  output logic [7:0] status
);

  logic [7:0] data_q [NUM_DATA];
  logic       overrun;
  logic       err_bcd;
  logic       busy;
  logic       data_hit;
  logic       cmd_hit;
  logic       clr_hit;
  logic       bcd_bad;
  logic       start;

  always_comb begin
    data_hit = write_strobe && (port_id <= PORT_HORA_TIM);
    cmd_hit  = write_strobe && (port_id == PORT_CMD);
    clr_hit  = write_strobe && (port_id == PORT_CLR);
`ifdef DEMUX_OUTPICO_BCD_CHECK_EN
    bcd_bad  = data_hit && !is_bcd(out_port);
`else
    bcd_bad  = 1'b0;
`endif
    // A zero command only updates cmd_out; it never launches a transfer.
    start    = cmd_hit && !busy && (out_port != 8'h00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DATA; i++) data_q[i] <= 8'h00;
      cmd_out <= 8'h00;
      overrun <= 1'b0;
      err_bcd <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DATA; i++) begin
        if (data_hit && !busy && !bcd_bad && (port_id == 8'(i)))
          data_q[i] <= out_port;
      end
      if (cmd_hit && !busy)
        cmd_out <= out_port;
      // Set takes priority over the clear port.
      if ((data_hit || cmd_hit) && busy)
        overrun <= 1'b1;
      else if (clr_hit)
        overrun <= 1'b0;
      if (bcd_bad)
        err_bcd <= 1'b1;
      else if (clr_hit)
        err_bcd <= 1'b0;
    end
  end

  rtc_wr_handshake u_handshake (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .wr_ack (wr_ack),
    .wr_req (wr_req),
    .busy   (busy)
  );

  assign seg_out      = data_q[0];
  assign min_out      = data_q[1];
  assign hora_out     = data_q[2];
  assign dia_out      = data_q[3];
  assign mes_out      = data_q[4];
  assign year_out     = data_q[5];
  assign seg_tim_out  = data_q[6];
  assign min_tim_out  = data_q[7];
  assign hora_tim_out = data_q[8];

  always_comb begin
    status               = 8'h00;
    status[STAT_BUSY]    = busy;
    status[STAT_OVERRUN] = overrun;
    status[STAT_ERR_BCD] = err_bcd;
  end

endmodule

// File: tb/tb_demux_outpico.sv
// Self-checking bench for demux_outpico: directed scenarios plus randomized
// traffic checked against a behavioural model of the port map and handshake.
module tb_demux_outpico;

`ifdef DEMUX_OUTPICO_BCD_CHECK_EN
  localparam bit BCD_EN = 1'b1;
`else
  localparam bit BCD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       write_strobe;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       wr_ack;
  logic [7:0] seg_out, min_out, hora_out, dia_out, mes_out, year_out;
  logic [7:0] seg_tim_out, min_tim_out, hora_tim_out, cmd_out, status;
  logic       wr_req;

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model
  logic [7:0] m_data [9];
  logic [7:0] m_cmd;
  logic       m_ovr, m_err, m_req, m_busy;

  always #5 clk = ~clk;

  demux_outpico dut (
    .clk(clk), .reset(reset), .write_strobe(write_strobe), .port_id(port_id),
    .out_port(out_port), .wr_ack(wr_ack),
    .seg_out(seg_out), .min_out(min_out), .hora_out(hora_out), .dia_out(dia_out),
    .mes_out(mes_out), .year_out(year_out), .seg_tim_out(seg_tim_out),
    .min_tim_out(min_tim_out), .hora_tim_out(hora_tim_out), .cmd_out(cmd_out),
    .wr_req(wr_req), .status(status)
  );

  function automatic logic [88:0] dut_vec();
    return {seg_out, min_out, hora_out, dia_out, mes_out, year_out, seg_tim_out,
            min_tim_out, hora_tim_out, cmd_out, wr_req, status};
  endfunction

  function automatic logic [88:0] model_vec();
    return {m_data[0], m_data[1], m_data[2], m_data[3], m_data[4], m_data[5],
            m_data[6], m_data[7], m_data[8], m_cmd, m_req,
            {5'b0, m_err, m_ovr, m_busy}};
  endfunction

  task automatic model_update(input logic s, input logic [7:0] id, input logic [7:0] d,
                              input logic a, input logic r);
    logic was_busy, is_data, is_cmd, is_clr, bad;
    if (r) begin
      for (int i = 0; i < 9; i++) m_data[i] = 8'h00;
      m_cmd = 8'h00; m_ovr = 1'b0; m_err = 1'b0; m_req = 1'b0; m_busy = 1'b0;
      return;
    end
    was_busy = m_busy;
    is_data  = s && (id < 8'd9);
    is_cmd   = s && (id == 8'h0A);
    is_clr   = s && (id == 8'h0C);
    bad      = BCD_EN && is_data && ((d[7:4] > 4'd9) || (d[3:0] > 4'd9));
    if (is_data && !was_busy && !bad) m_data[id] = d;
    if (is_cmd && !was_busy) m_cmd = d;
    if ((is_data || is_cmd) && was_busy) m_ovr = 1'b1;
    else if (is_clr) m_ovr = 1'b0;
    if (bad) m_err = 1'b1;
    else if (is_clr) m_err = 1'b0;
    // transfer lifecycle: request until ack high, stay busy until ack low
    if (!was_busy) begin
      if (is_cmd && d != 8'h00) begin m_req = 1'b1; m_busy = 1'b1; end
    end else if (m_req) begin
      if (a) m_req = 1'b0;
    end else if (!a) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic step(input logic s, input logic [7:0] id, input logic [7:0] d,
                      input logic a, input logic r);
    write_strobe = s; port_id = id; out_port = d; wr_ack = a; reset = r;
    @(posedge clk);
    model_update(s, id, d, a, r);
    #1;
    write_strobe = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    n_cmp++;
    if (dut_vec() !== 89'h0) begin
      n_err++; $display("FAIL reset_outputs got %h want 0", dut_vec());
    end
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h00, 8'h45, 1'b0, 1'b0);
    n_cmp++;
    if (seg_out !== 8'h45) begin
      n_err++; $display("FAIL seg_write got %h want 45", seg_out);
    end
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL seg_write_others got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_data_ports();
    for (int p = 0; p < 9; p++) begin
      step(1'b1, 8'(p), 8'($urandom_range(0, 9) * 16 + $urandom_range(0, 9)), 1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_err++; $display("FAIL data_port_%0d got %h want %h", p, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_handshake();
    logic [1:0] want [8];
    // {wr_req, busy} after each step: cmd, 3 idle, ack, ack, ack low, idle
    want = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
    for (int c = 0; c < 8; c++) begin
      if (c == 0) step(1'b1, 8'h0A, 8'h01, 1'b0, 1'b0);
      else        step(1'b0, 8'h00, 8'h00, (c == 4 || c == 5), 1'b0);
      n_cmp++;
      if ({wr_req, status[0]} !== want[c] || dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL handshake_cyc%0d got req/busy %b want %b (full %h vs %h)",
                 c, {wr_req, status[0]}, want[c], dut_vec(), model_vec());
      end
    end
    n_cmp++;
    if (cmd_out !== 8'h01) begin
      n_err++; $display("FAIL cmd_latch got %h want 01", cmd_out);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] min_before;
    min_before = min_out;
    step(1'b1, 8'h0A, 8'h05, 1'b0, 1'b0);
    step(1'b1, 8'h01, 8'h30, 1'b0, 1'b0);
    n_cmp++;
    if (min_out !== min_before || status[1] !== 1'b1) begin
      n_err++; $display("FAIL overrun_set got min %h ovr %b want min %h ovr 1",
                        min_out, status[1], min_before);
    end
    step(1'b1, 8'h0C, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (status[1] !== 1'b0 || status[0] !== 1'b1) begin
      n_err++; $display("FAIL overrun_clear got status %h want busy=1 ovr=0", status);
    end
    step(1'b1, 8'h0A, 8'h07, 1'b0, 1'b0);
    n_cmp++;
    if (status[1] !== 1'b1 || cmd_out !== 8'h05) begin
      n_err++; $display("FAIL overrun_cmd got status %h cmd %h want ovr=1 cmd 05", status, cmd_out);
    end
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h0C, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (dut_vec() !== model_vec() || status !== 8'h00) begin
      n_err++; $display("FAIL overrun_end got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_ignored();
    logic [7:0] ids [4];
    logic [7:0] vals [4];
    ids  = '{8'h09, 8'h0B, 8'hFF, 8'h0A};
    vals = '{8'h5A, 8'h66, 8'h12, 8'h00};
    step(1'b1, 8'h0A, 8'h33, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, ids[k], vals[k], 1'b0, 1'b0);
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== model_vec() || wr_req !== 1'b0) begin
        n_err++; $display("FAIL ignored_port_%h got %h want %h", ids[k], dut_vec(), model_vec());
      end
    end
    n_cmp++;
    if (cmd_out !== 8'h00) begin
      n_err++; $display("FAIL zero_cmd got %h want 00", cmd_out);
    end
  endtask

  task automatic test_bcd();
    logic [7:0] hora_before, want_hora;
    hora_before = hora_out;
    want_hora   = BCD_EN ? hora_before : 8'h3A;
    step(1'b1, 8'h02, 8'h3A, 1'b0, 1'b0);
    n_cmp++;
    if (hora_out !== want_hora || status[2] !== BCD_EN) begin
      n_err++; $display("FAIL bcd_check got hora %h err %b want hora %h err %b",
                        hora_out, status[2], want_hora, BCD_EN);
    end
    step(1'b1, 8'h0C, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (status[2] !== 1'b0) begin
      n_err++; $display("FAIL bcd_clear got %b want 0", status[2]);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'h0A, 8'h09, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    n_cmp++;
    if (wr_req !== 1'b0 || status[0] !== 1'b0) begin
      n_err++; $display("FAIL reset_mid got req %b busy %b want 0 0", wr_req, status[0]);
    end
    step(1'b1, 8'h0A, 8'h02, 1'b0, 1'b0);
    n_cmp++;
    if (wr_req !== 1'b1 || status[0] !== 1'b1) begin
      n_err++; $display("FAIL restart got req %b busy %b want 1 1", wr_req, status[0]);
    end
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (dut_vec() !== model_vec() || status[0] !== 1'b0) begin
      n_err++; $display("FAIL restart_done got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_random();
    logic       s, a;
    logic [7:0] id, d;
    int         bad = 0;
    a = 1'b0;
    for (int n = 0; n < 600; n++) begin
      s  = ($urandom_range(0, 2) != 0);
      id = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 13));
      if (id == 8'h0A && $urandom_range(0, 1) == 1) id = 8'h0A;
      d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) a = ~a;
      step(s, id, d, a, ($urandom_range(0, 199) == 0));
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_err++; bad++;
        if (bad <= 5)
          $display("FAIL random_step_%0d got %h want %h", n, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    write_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00; wr_ack = 1'b0; reset = 1'b1;
    for (int i = 0; i < 9; i++) m_data[i] = 8'h00;
    m_cmd = 8'h00; m_ovr = 1'b0; m_err = 1'b0; m_req = 1'b0; m_busy = 1'b0;
    test_reset();
    test_data_ports();
    test_handshake();
    test_overrun();
    test_ignored();
    test_bcd();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
